// File: rtl/pipe_skid_stage_if.sv
// -----------------------------------------------------------------------------
// pipe_skid_stage_if
// Handshake bundle between an upstream producer, a pipe_skid_stage and the
// downstream consumer.
//   in_valid   : upstream payload valid
//   in_ready   : stage can accept this cycle (flop-derived)
//   in_data    : upstream payload, DATA_W bits
//   out_valid  : out_data holds a valid payload
//   out_ready  : downstream accepts out_data this cycle
//   out_data   : payload to next stage, DATA_W bits
//   occupancy  : entries held in the stage (0, 1 or 2)
// Modports:
//   master : the environment around the stage (drives in_*, out_ready)
//   slave  : the stage itself
// -----------------------------------------------------------------------------
interface pipe_skid_stage_if #(
  parameter int DATA_W = 64
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occupancy;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, occupancy
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, occupancy
  );
endinterface

// File: rtl/pipe_skid_stage.sv
// -----------------------------------------------------------------------------
// pipe_skid_stage
// Pipeline stage register with valid/ready handshake, a two-entry skid buffer
// and synchronous flush. Empty or flushed slots carry NOP_VALUE so downstream
// always sees a harmless payload. in_ready is registered, so there is no
// combinational path from out_ready, in_valid or pipe_flush to in_ready.
// Parameters:
//   DATA_W    : payload width in bits
//   NOP_VALUE : bubble payload presented whenever the stage is empty
// Ports:
//   clk        : rising-edge clock
//   reset      : asynchronous active-high reset
//   pipe_flush : synchronous flush, empties both entries
//   bus        : handshake bundle (slave side), see pipe_skid_stage_if
// -----------------------------------------------------------------------------
module pipe_skid_stage #(
  parameter int                DATA_W    = 64,
  parameter logic [DATA_W-1:0] NOP_VALUE = {DATA_W{1'b0}}
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pipe_flush,
  pipe_skid_stage_if.slave      bus
);

  // Encoding equals the number of held entries, so the state register
  // drives occupancy directly.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [DATA_W-1:0] r_main;
  logic [DATA_W-1:0] w_main_next;
  logic [DATA_W-1:0] r_skid;
  logic [DATA_W-1:0] w_skid_next;
  logic              r_in_ready;
  logic              r_out_valid;
  logic              w_accept;
  logic              w_emit;

  assign w_accept = bus.in_valid && r_in_ready;
  assign w_emit   = r_out_valid && bus.out_ready;

  always_comb begin
    w_state_next = r_state;
    w_main_next  = r_main;
    w_skid_next  = r_skid;

    case (r_state)
      ST_EMPTY: begin
        if (w_accept) begin
          w_state_next = ST_ONE;
          w_main_next  = bus.in_data;
        end
      end
      ST_ONE: begin
        if (w_accept && w_emit) begin
          w_main_next = bus.in_data;
        end else if (w_accept) begin
          // Downstream stalled: park the new payload behind main.
          w_state_next = ST_FULL;
          w_skid_next  = bus.in_data;
        end else if (w_emit) begin
          w_state_next = ST_EMPTY;
          w_main_next  = NOP_VALUE;
        end
      end
      ST_FULL: begin
        if (w_emit) begin
          w_state_next = ST_ONE;
          w_main_next  = r_skid;
          w_skid_next  = NOP_VALUE;
        end
      end
      default: begin
        w_state_next = ST_EMPTY;
        w_main_next  = NOP_VALUE;
        w_skid_next  = NOP_VALUE;
      end
    endcase

    // Flush wins over every transition; an emit this cycle has still
    // completed downstream, but an accepted input is discarded.
    if (pipe_flush) begin
      w_state_next = ST_EMPTY;
      w_main_next  = NOP_VALUE;
      w_skid_next  = NOP_VALUE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_EMPTY;
      r_main      <= NOP_VALUE;
      r_skid      <= NOP_VALUE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_main      <= w_main_next;
      r_skid      <= w_skid_next;
      // Handshake outputs are precomputed from the next state so they come
      // straight from flops rather than through a state decode.
      r_in_ready  <= (w_state_next != ST_FULL);
      r_out_valid <= (w_state_next != ST_EMPTY);
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_main;
  assign bus.occupancy = r_state;

endmodule
